// File: rtl/muon_decay_interval_timer.sv
// Muon decay interval timer.
// Counts clock cycles from a start hit to a qualifying stop hit and hands the
// captured interval to readout over valid/ready. Windows that reach
// MAX_CYCLES without a stop are reported as timeouts.
module muon_decay_interval_timer #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 5_000_000,
  parameter int MIN_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_A,
  input  logic             hit_B,
  input  logic             enable,
  output logic [WIDTH-1:0] interval,
  output logic             interval_valid,
  input  logic             interval_ready,
  output logic             timeout_pulse,
  output logic [15:0]      timeout_count,
  output logic [15:0]      event_count,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_CYCLES);
  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_capture;
  logic             w_timeout;
  logic             w_release;

  logic r_a_meta, r_a_sync, r_a_dly;
  logic r_b_meta, r_b_sync, r_b_dly;
  logic w_hit_edge;

  logic [WIDTH-1:0] r_interval;
  logic             r_interval_valid;
  logic             r_timeout_pulse;
  logic [15:0]      r_timeout_count;
  logic [15:0]      r_event_count;

  // Two-flop synchronizers plus a delay flop per detector for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_a_dly  <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
      r_b_dly  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge
      // input, so the chain really is three stages deep.
      r_a_meta <= hit_A;
      r_a_sync <= r_a_meta;
      r_a_dly  <= r_a_sync;
      r_b_meta <= hit_B;
      r_b_sync <= r_b_meta;
      r_b_dly  <= r_b_sync;
    end
  end

  // Coincident A and B edges collapse into a single edge.
  assign w_hit_edge = (r_a_sync & ~r_a_dly) | (r_b_sync & ~r_b_dly);

  // State and interval counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic; in RUN, abort beats capture, which beats timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_hit_edge) begin
          w_state_nxt = S_RUN;
          w_count_nxt = WIDTH'(1);
        end
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (w_hit_edge && (r_count >= MIN_C)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
          w_count_nxt = '0;
        end else if (r_count == MAX_C) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (r_interval_valid && interval_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Result register, handshake flag, timeout strobe and saturating tallies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_interval       <= '0;
      r_interval_valid <= 1'b0;
      r_timeout_pulse  <= 1'b0;
      r_timeout_count  <= '0;
      r_event_count    <= '0;
    end else begin
      r_timeout_pulse <= w_timeout;
      if (w_capture) begin
        r_interval       <= r_count;
        r_interval_valid <= 1'b1;
        if (r_event_count != 16'hFFFF) r_event_count <= r_event_count + 16'd1;
      end else if (w_release) begin
        r_interval_valid <= 1'b0;
      end
      if (w_timeout && (r_timeout_count != 16'hFFFF)) begin
        r_timeout_count <= r_timeout_count + 16'd1;
      end
    end
  end

  assign interval       = r_interval;
  assign interval_valid = r_interval_valid;
  assign timeout_pulse  = r_timeout_pulse;
  assign timeout_count  = r_timeout_count;
  assign event_count    = r_event_count;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_muon_decay_interval_timer.sv
// Directed bench for muon_decay_interval_timer: a MIN=10/MAX=1000 instance for
// the measurement scenarios and a MIN=1/MAX=2 instance on a fast clock for
// counter saturation.
module tb_muon_decay_interval_timer;

  localparam int MIN_C = 10;
  localparam int MAX_C = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hit_A, hit_B, enable, interval_ready;
  logic [31:0] interval;
  logic        interval_valid, timeout_pulse, busy;
  logic [15:0] timeout_count, event_count;

  logic        clk2 = 1'b0;
  logic        rst2_n;
  logic        hit2_A, hit2_B, enable2, ready2;
  logic [7:0]  interval2;
  logic        valid2, tpulse2, busy2;
  logic [15:0] tcount2, ecount2;

  int checks   = 0;
  int failures = 0;
  int valid_seen = 0;
  int to_seen    = 0;
  int to_seen2   = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;
  always #1 clk2 = ~clk2;

  muon_decay_interval_timer #(.WIDTH(32), .MAX_CYCLES(MAX_C), .MIN_CYCLES(MIN_C)) dut (
    .clk(clk), .rst_n(rst_n), .hit_A(hit_A), .hit_B(hit_B), .enable(enable),
    .interval(interval), .interval_valid(interval_valid), .interval_ready(interval_ready),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count),
    .event_count(event_count), .busy(busy)
  );

  muon_decay_interval_timer #(.WIDTH(8), .MAX_CYCLES(2), .MIN_CYCLES(1)) dut_sat (
    .clk(clk2), .rst_n(rst2_n), .hit_A(hit2_A), .hit_B(hit2_B), .enable(enable2),
    .interval(interval2), .interval_valid(valid2), .interval_ready(ready2),
    .timeout_pulse(tpulse2), .timeout_count(tcount2),
    .event_count(ecount2), .busy(busy2)
  );

  // Count result rising edges and timeout strobes as seen from outside.
  always @(negedge clk) begin
    if (interval_valid && !prev_v) valid_seen++;
    prev_v = interval_valid;
    if (timeout_pulse) to_seen++;
  end

  always @(negedge clk2) begin
    if (tpulse2) to_seen2++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a();
    hit_A = 1'b1;
    @(negedge clk);
    hit_A = 1'b0;
  endtask

  task automatic pulse_b();
    hit_B = 1'b1;
    @(negedge clk);
    hit_B = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (interval_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: interval_valid got 0 expected 1 within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_timeout(input string name, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (timeout_pulse) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: timeout_pulse got 0 expected 1 within %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hit_A = 1'b0; hit_B = 1'b0; enable = 1'b0; interval_ready = 1'b0;
    #12;
    checks++;
    if ({interval, interval_valid, timeout_pulse, timeout_count, event_count, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got interval=%0d valid=%0d tp=%0d tc=%0d ec=%0d busy=%0d expected all 0",
               interval, interval_valid, timeout_pulse, timeout_count, event_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; interval_ready = 1'b1;
    idle(3);
  endtask

  task automatic test_basic_capture();
    pulse_a();
    idle(249);
    pulse_b();
    wait_valid("basic_valid", 20);
    checks++;
    if (interval !== 32'd250) begin
      failures++; $display("FAIL basic_interval: got %0d expected 250", interval);
    end
    checks++;
    if (event_count !== 16'd1) begin
      failures++; $display("FAIL basic_event_count: got %0d expected 1", event_count);
    end
    @(negedge clk);
    checks++;
    if (interval_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_one_cycle: got valid=%0d busy=%0d expected 0 0", interval_valid, busy);
    end
  endtask

  task automatic test_afterpulse();
    int v0;
    v0 = valid_seen;
    pulse_a();
    idle(4);
    pulse_b();
    idle(34);
    pulse_a();
    wait_valid("afterpulse_valid", 20);
    checks++;
    if (interval !== 32'd40) begin
      failures++; $display("FAIL afterpulse_interval: got %0d expected 40", interval);
    end
    idle(3);
    checks++;
    if (valid_seen - v0 !== 1) begin
      failures++; $display("FAIL afterpulse_results: got %0d expected 1", valid_seen - v0);
    end
    // stop exactly at MIN
    pulse_a();
    idle(9);
    pulse_b();
    wait_valid("min_valid", 20);
    checks++;
    if (interval !== 32'd10) begin
      failures++; $display("FAIL min_interval: got %0d expected 10", interval);
    end
    idle(3);
    // stop at MIN-1 is rejected, a later one at 20 is captured
    pulse_a();
    idle(8);
    pulse_b();
    idle(10);
    pulse_a();
    wait_valid("below_min_valid", 20);
    checks++;
    if (interval !== 32'd20) begin
      failures++; $display("FAIL below_min_interval: got %0d expected 20", interval);
    end
    checks++;
    if (event_count !== 16'd4) begin
      failures++; $display("FAIL afterpulse_event_count: got %0d expected 4", event_count);
    end
    idle(3);
  endtask

  task automatic test_timeout();
    int v0, t0;
    v0 = valid_seen; t0 = to_seen;
    pulse_a();
    idle(500);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL timeout_busy_run: got %0d expected 1", busy);
    end
    wait_timeout("timeout_pulse", 600);
    idle(2);
    checks++;
    if (timeout_count !== 16'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_state: got tc=%0d busy=%0d expected 1 0", timeout_count, busy);
    end
    checks++;
    if (to_seen - t0 !== 1 || valid_seen - v0 !== 0) begin
      failures++; $display("FAIL timeout_strobes: got pulses=%0d results=%0d expected 1 0", to_seen - t0, valid_seen - v0);
    end
    // stop coincident with count == MAX wins over the timeout
    pulse_a();
    idle(999);
    pulse_b();
    wait_valid("coincide_valid", 20);
    checks++;
    if (interval !== 32'd1000) begin
      failures++; $display("FAIL coincide_interval: got %0d expected 1000", interval);
    end
    idle(3);
    checks++;
    if (timeout_count !== 16'd1 || to_seen - t0 !== 1 || event_count !== 16'd5) begin
      failures++; $display("FAIL coincide_no_timeout: got tc=%0d pulses=%0d ec=%0d expected 1 1 5",
                           timeout_count, to_seen - t0, event_count);
    end
  endtask

  task automatic test_backpressure();
    interval_ready = 1'b0;
    pulse_a();
    idle(49);
    pulse_b();
    wait_valid("bp_valid", 20);
    checks++;
    if (interval !== 32'd50) begin
      failures++; $display("FAIL bp_interval: got %0d expected 50", interval);
    end
    for (int k = 0; k < 3; k++) begin
      idle(9);
      if (k % 2 == 0) pulse_a(); else pulse_b();
    end
    idle(5);
    checks++;
    if (interval !== 32'd50 || interval_valid !== 1'b1 || busy !== 1'b1 || event_count !== 16'd6) begin
      failures++; $display("FAIL bp_hold: got interval=%0d valid=%0d busy=%0d ec=%0d expected 50 1 1 6",
                           interval, interval_valid, busy, event_count);
    end
    interval_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (interval_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release: got valid=%0d busy=%0d expected 0 0", interval_valid, busy);
    end
    pulse_a();
    idle(29);
    pulse_b();
    wait_valid("bp_next_valid", 20);
    checks++;
    if (interval !== 32'd30 || event_count !== 16'd7) begin
      failures++; $display("FAIL bp_next: got interval=%0d ec=%0d expected 30 7", interval, event_count);
    end
    idle(3);
  endtask

  task automatic test_abort_reset();
    int v0, t0;
    v0 = valid_seen; t0 = to_seen;
    pulse_a();
    idle(299);
    enable = 1'b0;
    idle(3);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL abort_busy: got %0d expected 0", busy);
    end
    enable = 1'b1;
    idle(1100);
    checks++;
    if (valid_seen - v0 !== 0 || to_seen - t0 !== 0 || timeout_count !== 16'd1 || event_count !== 16'd7) begin
      failures++; $display("FAIL abort_silent: got results=%0d pulses=%0d tc=%0d ec=%0d expected 0 0 1 7",
                           valid_seen - v0, to_seen - t0, timeout_count, event_count);
    end
    // asynchronous reset while in RUN
    pulse_a();
    idle(100);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rst_run_busy_before: got %0d expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({interval, interval_valid, timeout_pulse, timeout_count, event_count, busy} !== '0) begin
      failures++; $display("FAIL rst_run_outputs: got interval=%0d valid=%0d tc=%0d ec=%0d busy=%0d expected all 0",
                           interval, interval_valid, timeout_count, event_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    // asynchronous reset while in HOLD
    interval_ready = 1'b0;
    pulse_a();
    idle(19);
    pulse_b();
    wait_valid("rst_hold_valid", 20);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({interval, interval_valid, timeout_pulse, timeout_count, event_count, busy} !== '0) begin
      failures++; $display("FAIL rst_hold_outputs: got interval=%0d valid=%0d tc=%0d ec=%0d busy=%0d expected all 0",
                           interval, interval_valid, timeout_count, event_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    interval_ready = 1'b1;
    idle(3);
  endtask

  task automatic test_edges();
    int v0, t0;
    // simultaneous A and B start a single measurement
    hit_A = 1'b1; hit_B = 1'b1;
    @(negedge clk);
    hit_A = 1'b0; hit_B = 1'b0;
    idle(59);
    pulse_b();
    wait_valid("simul_valid", 20);
    checks++;
    if (interval !== 32'd60 || event_count !== 16'd1) begin
      failures++; $display("FAIL simul_capture: got interval=%0d ec=%0d expected 60 1", interval, event_count);
    end
    idle(3);
    // a held level gives only the start edge
    v0 = valid_seen; t0 = to_seen;
    hit_A = 1'b1;
    idle(500);
    checks++;
    if (valid_seen - v0 !== 0 || busy !== 1'b1) begin
      failures++; $display("FAIL held_no_stop: got results=%0d busy=%0d expected 0 1", valid_seen - v0, busy);
    end
    hit_A = 1'b0;
    wait_timeout("held_timeout", 600);
    idle(2);
    checks++;
    if (timeout_count !== 16'd1 || valid_seen - v0 !== 0) begin
      failures++; $display("FAIL held_timeout_count: got tc=%0d results=%0d expected 1 0", timeout_count, valid_seen - v0);
    end
  endtask

  task automatic run_sat_periods(input int n);
    for (int i = 0; i < n; i++) begin
      hit2_A = 1'b1;
      @(negedge clk2);
      hit2_A = 1'b0;
      @(negedge clk2);
      @(negedge clk2);
    end
    repeat (8) @(negedge clk2);
  endtask

  task automatic test_saturation();
    @(negedge clk2);
    rst2_n = 1'b1;
    run_sat_periods(65534);
    checks++;
    if (tcount2 !== 16'hFFFE || to_seen2 !== 65534) begin
      failures++; $display("FAIL sat_pre: got tc=%0d pulses=%0d expected 65534 65534", tcount2, to_seen2);
    end
    run_sat_periods(10);
    checks++;
    if (tcount2 !== 16'hFFFF || to_seen2 !== 65544 || ecount2 !== 16'd0) begin
      failures++; $display("FAIL sat_post: got tc=%0d pulses=%0d ec=%0d expected 65535 65544 0",
                           tcount2, to_seen2, ecount2);
    end
  endtask

  initial begin
    rst2_n = 1'b0; hit2_A = 1'b0; hit2_B = 1'b0; enable2 = 1'b1; ready2 = 1'b1;
    test_reset();
    test_basic_capture();
    test_afterpulse();
    test_timeout();
    test_backpressure();
    test_abort_reset();
    test_edges();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
